// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter behind a power-of-two byte FIFO; the start bit goes out one edge after a byte lands in an idle, empty block.
// tx_ready is low only while the FIFO is full or in reset. Back-to-back frames leave no idle gap between them.

module uart_tx_fifo_buf #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                    clk_10,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [DW-1:0]           i_dat,
    input  logic                    i_pop,
    output logic [DW-1:0]           o_dat,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_10) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_10) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    assign o_dat   = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_10,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CW-1:0]   BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CW_ONE   = CW'(1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic            r_tx;
    logic            w_tx_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_nempty;
    logic [7:0]      w_head;
    logic [CNTW-1:0] w_count;

    assign tx_ready      = !rst && (w_count < FULL_CNT);
    assign w_push        = tx_valid && tx_ready;
    assign w_fifo_nempty = (w_count != '0);

    uart_tx_fifo_buf #(
        .DEPTH (FIFO_DEPTH),
        .DW    (8)
    ) u_fifo (
        .clk_10  (clk_10),
        .rst     (rst),
        .i_push  (w_push),
        .i_dat   (tx_data),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk_10) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // The shift register is consumed LSB first; r_tx always holds the bit being sent.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_fifo_nempty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_cnt_nxt   = BIT_LAST;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = BIT_LAST;
                end else begin
                    w_cnt_nxt = r_cnt - CW_ONE;
                end
            end
            DATA: begin
                if (r_cnt == '0) begin
                    w_cnt_nxt = BIT_LAST;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_tx_nxt    = r_shift[0];
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW_ONE;
                end
            end
            STOP: begin
                if (r_cnt == '0) begin
                    if (w_fifo_nempty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_cnt_nxt   = BIT_LAST;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign uart_tx    = r_tx;
    assign busy       = (r_state != IDLE) || w_fifo_nempty;
    assign fifo_count = w_count;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: randomized pushes against a frame-timing reference model, plus a mid-bit 8N1 loopback receiver.
module tb_uart_tx_fifo;
    localparam int CPB   = 9;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic                      clk_10;
    logic                      rst;
    logic [7:0]                tx_data;
    logic                      tx_valid;
    logic                      tx_ready;
    logic                      uart_tx;
    logic                      busy;
    logic [$clog2(DEPTH):0]    fifo_count;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_10     (clk_10),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk_10 = 1'b0;
    always #50 clk_10 = ~clk_10;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_chk++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp_v, $time);
        end
    endtask

    // Reference model: queued bytes, the byte on the wire, and cycles left in its frame.
    logic [7:0] q[$];
    logic [7:0] exp_rx[$];
    logic [7:0] cur = 8'h00;
    int         frame_left = 0;
    logic       m_push;
    logic       m_pop;

    always @(posedge clk_10) begin
        if (rst) begin
            q.delete();
            frame_left = 0;
        end else begin
            m_push = tx_valid && (q.size() < DEPTH);
            m_pop  = (frame_left <= 1) && (q.size() != 0);
            if (frame_left > 1) begin
                frame_left = frame_left - 1;
            end else if (m_pop) begin
                cur = q.pop_front();
                exp_rx.push_back(cur);
                frame_left = FRAME;
            end else begin
                frame_left = 0;
            end
            if (m_push) q.push_back(tx_data);
        end
    end

    function automatic logic exp_line();
        int k;
        int b;
        if (frame_left == 0) return 1'b1;
        k = FRAME - frame_left;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return cur[b-1];
    endfunction

    always @(negedge clk_10) begin
        #20;
        if (chk_en) begin
            check("line", uart_tx, exp_line());
            check("count", fifo_count, q.size());
            check("busy", busy, (frame_left != 0 || q.size() != 0));
            check("ready", tx_ready, (!rst && q.size() < DEPTH));
        end
    end

    // Loopback receiver: start detected on the first low sample, then mid-bit sampling.
    bit         rx_on = 1'b0;
    int         rx_t = 0;
    int         rx_n = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [31:0] rx_exp;

    always @(negedge clk_10) begin
        if (rst || !chk_en) begin
            rx_on = 1'b0;
            exp_rx.delete();
        end else if (!rx_on) begin
            if (uart_tx === 1'b0) begin
                rx_on = 1'b1;
                rx_t  = 0;
            end
        end else begin
            rx_t++;
            if (rx_t == CPB / 2) begin
                check("rx_start", uart_tx, 0);
            end else if ((rx_t % CPB) == CPB / 2 && (rx_t / CPB) <= 8) begin
                rx_sh[rx_t / CPB - 1] = uart_tx;
            end else if (rx_t == 9 * CPB + CPB / 2) begin
                check("rx_stop", uart_tx, 1);
                rx_exp = (exp_rx.size() != 0) ? 32'(exp_rx.pop_front()) : 32'hFFFF_FFFF;
                check("rx_byte", rx_sh, rx_exp);
                rx_n++;
                rx_on = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        @(negedge clk_10);
        tx_valid = 1'b1;
        tx_data  = b;
        #1;
        n = 0;
        while (!tx_ready && n < 3 * FRAME) begin
            @(negedge clk_10);
            #1;
            n++;
        end
        if (n >= 3 * FRAME) check("send_rdy", tx_ready, 1);
        @(posedge clk_10);
    endtask

    task automatic release_bus();
        @(negedge clk_10);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((frame_left != 0 || q.size() != 0) && n < budget) begin
            @(negedge clk_10);
            n++;
        end
        #1;
        check("idle_tmo", busy, 0);
    endtask

    initial begin
        int n;
        int n0;
        int n_low;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        @(posedge clk_10);
        #1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk_10);
        #1;
        check("rst_line", uart_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_rdy", tx_ready, 0);
        check("rst_cnt", fifo_count, 0);

        // Single byte, offered on the first edge after reset release.
        @(negedge clk_10);
        rst      = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        @(posedge clk_10);
        #1;
        check("first_accept", fifo_count, 1);
        release_bus();
        #1;
        n = 0;
        while (busy && n < 3 * FRAME) begin
            n++;
            @(negedge clk_10);
            #1;
        end
        check("busy_len", n, FRAME + 1);

        // Back-to-back frames.
        n0 = rx_n;
        send(8'hA5);
        send(8'h3C);
        send(8'hFF);
        release_bus();
        wait_idle(5 * FRAME);
        check("b2b_rx", rx_n - n0, 3);

        // Full FIFO with a sixth byte held off.
        n0 = rx_n;
        for (int i = 1; i <= 5; i++) send(8'(i));
        @(negedge clk_10);
        tx_valid = 1'b1;
        tx_data  = 8'h06;
        #1;
        check("full_cnt", fifo_count, DEPTH);
        check("full_rdy", tx_ready, 0);
        send(8'h06);
        release_bus();
        wait_idle(8 * FRAME);
        check("full_rx", rx_n - n0, 6);

        // Push on the same edge as a pop with two bytes queued.
        n0 = rx_n;
        send(8'h81);
        send(8'h42);
        send(8'h24);
        release_bus();
        n = 0;
        while (frame_left != 1 && n < 2 * FRAME) begin
            @(negedge clk_10);
            n++;
        end
        tx_valid = 1'b1;
        tx_data  = 8'h18;
        @(posedge clk_10);
        release_bus();
        #1;
        check("pushpop_cnt", fifo_count, 2);
        wait_idle(6 * FRAME);
        check("pushpop_rx", rx_n - n0, 4);

        // Reset in the middle of data bit 3.
        send(8'h96);
        send(8'h11);
        send(8'h22);
        release_bus();
        n = 0;
        while (frame_left != FRAME - 4 * CPB - CPB / 2 && n < 2 * FRAME) begin
            @(negedge clk_10);
            n++;
        end
        n0  = rx_n;
        rst = 1'b1;
        @(negedge clk_10);
        #1;
        check("midrst_line", uart_tx, 1);
        check("midrst_cnt", fifo_count, 0);
        check("midrst_busy", busy, 0);
        rst   = 1'b0;
        n_low = 0;
        repeat (3 * FRAME) begin
            @(negedge clk_10);
            #1;
            if (uart_tx !== 1'b1) n_low++;
        end
        check("midrst_quiet", n_low, 0);
        check("midrst_rx", rx_n - n0, 0);
        send(8'hC3);
        release_bus();
        wait_idle(3 * FRAME);
        check("postrst_rx", rx_n - n0, 1);

        // Random traffic with random gaps.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                send(8'($urandom));
            end else begin
                release_bus();
                repeat ($urandom_range(1, 12 * CPB)) @(negedge clk_10);
            end
        end
        release_bus();
        wait_idle(8 * FRAME);

        // Loopback of every byte value.
        n0 = rx_n;
        for (int i = 0; i < 256; i++) send(8'(i));
        release_bus();
        wait_idle(6 * FRAME);
        repeat (4) @(negedge clk_10);
        check("loop_rx", rx_n - n0, 256);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
